miner_job_dispatcher: RTL and testbench

//  Host-side end of the miner core interface: deserialises job packets from a byte stream and drives the

---
 rtl/miner_pkg.sv | 29 ++
 rtl/miner_result_serializer.sv | 53 +++++
 rtl/miner_job_dispatcher.sv | 171 +++++++++++++++++
 tb/tb_miner_job_dispatcher.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared constants, result tags and FSM state type for the miner job dispatcher.
// Optional feature macro: MINER_JOB_CHECKSUM_EN (adds a trailing XOR checksum byte to each job packet).
package miner_pkg;

  localparam int BUDGET_W      = 40;
  localparam int PAYLOAD_BYTES = 52;
  localparam int JOB_W         = PAYLOAD_BYTES * 8;
  localparam int RESULT_BYTES  = 5;

`ifdef MINER_JOB_CHECKSUM_EN
  localparam int JOB_BYTES   = 53;
  localparam bit CHECKSUM_EN = 1'b1;
`else
  localparam int JOB_BYTES   = 52;
  localparam bit CHECKSUM_EN = 1'b0;
`endif

  localparam logic [7:0] TAG_FOUND     = 8'h01;
  localparam logic [7:0] TAG_EXHAUSTED = 8'h02;
  localparam logic [7:0] TAG_NAK       = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_TX   = 2'd3
  } state_e;

endpackage

// File: rtl/miner_result_serializer.sv
// Sends one {tag, 32-bit payload} result as five bytes over a valid/ready byte stream.
module miner_result_serializer
  import miner_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [7:0]  tag_i,
  input  logic [31:0] payload_i,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic        done_o
);

  logic [31:0] shift_q;
  logic [2:0]  left_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        fire_s;

  assign fire_s     = tx_valid_q && tx_ready_i;
  assign done_o     = fire_s && (left_q == 3'd0);
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;

  // Byte sequencer: tag goes out first, then payload MSB to LSB
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q    <= 32'd0;
      left_q     <= 3'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
    end else if (load_i) begin
      shift_q    <= payload_i;
      left_q     <= 3'(RESULT_BYTES - 1);
      tx_data_q  <= tag_i;
      tx_valid_q <= 1'b1;
    end else if (fire_s) begin
      if (left_q == 3'd0) begin
        tx_data_q  <= 8'd0;
        tx_valid_q <= 1'b0;
      end else begin
        tx_data_q <= shift_q[31:24];
        shift_q   <= {shift_q[23:0], 8'd0};
        left_q    <= left_q - 3'd1;
      end
    end else begin
      tx_valid_q <= tx_valid_q;
    end
  end

endmodule

// File: rtl/miner_job_dispatcher.sv
// Host-side miner job dispatcher: byte-stream job intake, bounded scan, 5-byte result frame.
// Optional feature macro: MINER_JOB_CHECKSUM_EN (53-byte packets with XOR checksum, NAK on mismatch).
module miner_job_dispatcher
  import miner_pkg::*;
#(
  parameter int LOOP_LOG2    = 5,
  parameter int DRAIN_CYCLES = 72
) (
  input  logic         hash_clk,
  input  logic         reset_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [255:0] midstate,
  output logic [95:0]  work_data,
  output logic [31:0]  nonce_min,
  output logic [31:0]  nonce_max,
  output logic         miner_reset,
  input  logic [31:0]  golden_nonce,
  input  logic         new_golden_nonce,
  output logic         busy
);

  state_e              state_q;
  logic [5:0]          byte_cnt_q;
  logic [JOB_W-1:0]    job_q;
  logic [BUDGET_W-1:0] budget_q;
  logic [7:0]          csum_q;
  logic                nak_q;
  logic                rx_ready_q;
  logic                miner_reset_q;
  logic                busy_q;

  logic                rx_fire_s;
  logic [BUDGET_W-1:0] span_s;
  logic [BUDGET_W-1:0] budget_init_s;
  logic                frame_load_s;
  logic [7:0]          frame_tag_s;
  logic [31:0]         frame_payload_s;
  logic                tx_done_s;

  assign midstate    = job_q[JOB_W-1 -: 256];
  assign work_data   = job_q[159:64];
  assign nonce_min   = job_q[63:32];
  assign nonce_max   = job_q[31:0];
  assign rx_ready    = rx_ready_q;
  assign miner_reset = miner_reset_q;
  assign busy        = busy_q;
  assign rx_fire_s   = rx_valid && rx_ready_q;

  // Span is widened before the +1 so the full 2**32 range fits
  assign span_s        = {8'd0, nonce_max - nonce_min} + 40'd1;
  assign budget_init_s = (span_s << LOOP_LOG2) + BUDGET_W'(DRAIN_CYCLES);

  // Result frame selection; FOUND takes priority over budget expiry
  always_comb begin
    frame_load_s    = 1'b0;
    frame_tag_s     = TAG_NAK;
    frame_payload_s = 32'd0;
    case (state_q)
      ST_LOAD: begin
        if (nak_q) begin
          frame_load_s = 1'b1;
        end else if (nonce_max < nonce_min) begin
          frame_load_s    = 1'b1;
          frame_tag_s     = TAG_EXHAUSTED;
          frame_payload_s = nonce_max;
        end else begin
          frame_load_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (new_golden_nonce) begin
          frame_load_s    = 1'b1;
          frame_tag_s     = TAG_FOUND;
          frame_payload_s = golden_nonce;
        end else if (budget_q <= 40'd1) begin
          frame_load_s    = 1'b1;
          frame_tag_s     = TAG_EXHAUSTED;
          frame_payload_s = nonce_max;
        end else begin
          frame_load_s = 1'b0;
        end
      end
      default: frame_load_s = 1'b0;
    endcase
  end

  // Main job FSM with registered handshake and miner-control outputs
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= 6'd0;
      job_q         <= '0;
      budget_q      <= '0;
      csum_q        <= 8'd0;
      nak_q         <= 1'b0;
      rx_ready_q    <= 1'b1;
      miner_reset_q <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_fire_s) begin
            csum_q <= csum_q ^ rx_data;
            if (byte_cnt_q < 6'(PAYLOAD_BYTES)) begin
              job_q <= {job_q[JOB_W-9:0], rx_data};
            end
            if (byte_cnt_q == 6'(JOB_BYTES - 1)) begin
              nak_q      <= CHECKSUM_EN && (csum_q != rx_data);
              csum_q     <= 8'd0;
              byte_cnt_q <= 6'd0;
              rx_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= ST_LOAD;
            end else begin
              byte_cnt_q <= byte_cnt_q + 6'd1;
            end
          end
        end
        ST_LOAD: begin
          if (frame_load_s) begin
            state_q <= ST_TX;
          end else begin
            budget_q      <= budget_init_s;
            miner_reset_q <= 1'b0;
            state_q       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (frame_load_s) begin
            miner_reset_q <= 1'b1;
            state_q       <= ST_TX;
          end else begin
            budget_q <= budget_q - 40'd1;
          end
        end
        ST_TX: begin
          if (tx_done_s) begin
            nak_q      <= 1'b0;
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          miner_reset_q <= 1'b1;
          rx_ready_q    <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  miner_result_serializer u_serializer (
    .clk_i      (hash_clk),
    .rst_ni     (reset_n),
    .load_i     (frame_load_s),
    .tag_i      (frame_tag_s),
    .payload_i  (frame_payload_s),
    .tx_ready_i (tx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .done_o     (tx_done_s)
  );

endmodule

// File: tb/tb_miner_job_dispatcher.sv
// Directed self-checking bench for miner_job_dispatcher (LOOP_LOG2=5, DRAIN_CYCLES=72).
module tb_miner_job_dispatcher;

  logic         hash_clk = 1'b0;
  logic         reset_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [255:0] midstate;
  logic [95:0]  work_data;
  logic [31:0]  nonce_min;
  logic [31:0]  nonce_max;
  logic         miner_reset;
  logic [31:0]  golden_nonce;
  logic         new_golden_nonce;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [255:0] MS = 256'h00112233_44556677_8899AABB_CCDDEEFF_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [95:0]  WD = 96'hFEDCBA98_76543210_A5A55A5A;

  miner_job_dispatcher #(.LOOP_LOG2(5), .DRAIN_CYCLES(72)) dut (
    .hash_clk(hash_clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .midstate(midstate), .work_data(work_data), .nonce_min(nonce_min), .nonce_max(nonce_max),
    .miner_reset(miner_reset), .golden_nonce(golden_nonce), .new_golden_nonce(new_golden_nonce),
    .busy(busy)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic put_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (!rx_ready && n < 2000) begin
      @(posedge hash_clk); #1; n++;
    end
    if (n >= 2000) begin
      vectors++; miscompares++;
      $display("FAIL rx_ready_timeout got=%0b want=1", rx_ready);
    end
    rx_data = b; rx_valid = 1'b1;
    @(posedge hash_clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [255:0] ms, input logic [95:0] wd,
                             input logic [31:0] nmin, input logic [31:0] nmax,
                             input logic [7:0] csum_flip);
    logic [415:0] pkt;
    logic [7:0]   b;
    logic [7:0]   x;
    pkt = {ms, wd, nmin, nmax};
    x = csum_flip;
    for (int i = 0; i < 52; i++) begin
      b = pkt[415 - 8*i -: 8];
      x = x ^ b;
      put_byte(b);
    end
`ifdef MINER_JOB_CHECKSUM_EN
    put_byte(x);
`endif
  endtask

  task automatic wait_run(output int ok);
    int n;
    n = 0;
    while (miner_reset && n < 200) begin
      @(posedge hash_clk); #1; n++;
    end
    ok = (n < 200) ? 1 : 0;
  endtask

  task automatic collect_frame(input int stall, output logic [39:0] frame,
                               output int unstable, output int rxbad, output int tmo);
    logic [7:0] d;
    int n;
    frame = 40'd0; unstable = 0; rxbad = 0; tmo = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!tx_valid && n < 2000) begin
        @(posedge hash_clk); #1; n++;
      end
      if (n >= 2000) begin
        tmo = 1;
        return;
      end
      d = tx_data;
      for (int s = 0; s < stall; s++) begin
        @(posedge hash_clk); #1;
        if (tx_data !== d || tx_valid !== 1'b1) unstable++;
        if (rx_ready !== 1'b0) rxbad++;
      end
      if (rx_ready !== 1'b0) rxbad++;
      tx_ready = 1'b1;
      @(posedge hash_clk); #1;
      tx_ready = 1'b0;
      frame = {frame[31:0], d};
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_rx_ready got=%0b want=1", rx_ready); end
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid got=%0b want=0", tx_valid); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    vectors++; if (miner_reset !== 1'b1) begin miscompares++; $display("FAIL reset_miner_reset got=%0b want=1", miner_reset); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b want=0", busy); end
    vectors++; if (midstate !== 256'd0 || nonce_max !== 32'd0) begin miscompares++; $display("FAIL reset_job_regs got=%h/%h want=0", midstate, nonce_max); end
    @(posedge hash_clk); #1;
    reset_n = 1'b1;
    @(posedge hash_clk); #1;
  endtask

  task automatic test_found();
    logic [39:0] f; int u, r, t, ok;
    send_packet(MS, WD, 32'h00000077, 32'h00000077, 8'h00);
    vectors++; if (midstate !== MS) begin miscompares++; $display("FAIL found_midstate got=%h want=%h", midstate, MS); end
    vectors++; if (work_data !== WD) begin miscompares++; $display("FAIL found_work_data got=%h want=%h", work_data, WD); end
    vectors++; if (nonce_min !== 32'h77 || nonce_max !== 32'h77) begin miscompares++; $display("FAIL found_nonces got=%h/%h want=77/77", nonce_min, nonce_max); end
    vectors++; if (busy !== 1'b1 || rx_ready !== 1'b0) begin miscompares++; $display("FAIL found_load_flags got busy=%0b rx_ready=%0b want 1/0", busy, rx_ready); end
    wait_run(ok);
    vectors++; if (ok !== 1) begin miscompares++; $display("FAIL found_run_entry got=%0d want=1", ok); end
    repeat (5) begin @(posedge hash_clk); #1; end
    golden_nonce = 32'h1234ABCD; new_golden_nonce = 1'b1;
    @(posedge hash_clk); #1;
    new_golden_nonce = 1'b0;
    vectors++; if (miner_reset !== 1'b1) begin miscompares++; $display("FAIL found_miner_reset got=%0b want=1", miner_reset); end
    collect_frame(0, f, u, r, t);
    vectors++; if (f !== 40'h01_1234ABCD || t !== 0) begin miscompares++; $display("FAIL found_frame got=%h tmo=%0d want=011234abcd", f, t); end
    vectors++; if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL found_idle got rx_ready=%0b tx_valid=%0b busy=%0b want 1/0/0", rx_ready, tx_valid, busy); end
  endtask

  task automatic test_exhausted();
    logic [39:0] f; int u, r, t, runs, n;
    send_packet(MS, WD, 32'h00000100, 32'h0000010F, 8'h00);
    runs = 0; n = 0;
    while (!tx_valid && n < 3000) begin
      @(posedge hash_clk); #1; n++;
      if (miner_reset === 1'b0) runs++;
    end
    vectors++; if (runs !== (16 << 5) + 72) begin miscompares++; $display("FAIL exhausted_run_cycles got=%0d want=%0d", runs, (16 << 5) + 72); end
    collect_frame(0, f, u, r, t);
    vectors++; if (f !== 40'h02_0000010F || t !== 0) begin miscompares++; $display("FAIL exhausted_frame got=%h tmo=%0d want=020000010f", f, t); end
  endtask

  task automatic test_inverted_range();
    logic [39:0] f; int u, r, t, runs, n;
    golden_nonce = 32'hFFFF0000; new_golden_nonce = 1'b1;
    send_packet(MS, WD, 32'h00000005, 32'h00000004, 8'h00);
    runs = 0; n = 0;
    while (!tx_valid && n < 100) begin
      @(posedge hash_clk); #1; n++;
      if (miner_reset !== 1'b1) runs++;
    end
    vectors++; if (runs !== 0) begin miscompares++; $display("FAIL inverted_miner_released got=%0d want=0", runs); end
    collect_frame(0, f, u, r, t);
    new_golden_nonce = 1'b0;
    vectors++; if (f !== 40'h02_00000004 || t !== 0) begin miscompares++; $display("FAIL inverted_frame got=%h tmo=%0d want=0200000004", f, t); end
  endtask

  task automatic test_back_pressure();
    logic [39:0] f; int u, r, t, extra;
    send_packet(MS, WD, 32'hDEADBEEF, 32'hDEADBEEF, 8'h00);
    collect_frame(10, f, u, r, t);
    vectors++; if (f !== 40'h02_DEADBEEF || t !== 0) begin miscompares++; $display("FAIL bp_frame got=%h tmo=%0d want=02deadbeef", f, t); end
    vectors++; if (u !== 0) begin miscompares++; $display("FAIL bp_stable got=%0d unstable samples want=0", u); end
    vectors++; if (r !== 0) begin miscompares++; $display("FAIL bp_rx_ready_low got=%0d bad samples want=0", r); end
    vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL bp_rx_ready_after got=%0b want=1", rx_ready); end
    extra = 0;
    repeat (4) begin @(posedge hash_clk); #1; if (tx_valid !== 1'b0) extra++; end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL bp_no_duplicate got=%0d want=0", extra); end
  endtask

  task automatic test_reset_mid_run();
    logic [39:0] f; int u, r, t, ok;
    send_packet(MS, WD, 32'h00000000, 32'hFFFFFFFF, 8'h00);
    wait_run(ok);
    vectors++; if (ok !== 1 || nonce_max !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL rst_run_entry got ok=%0d max=%h want 1/ffffffff", ok, nonce_max); end
    repeat (20) begin @(posedge hash_clk); #1; end
    #1; reset_n = 1'b0; #1;
    vectors++; if (miner_reset !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_async_miner got mr=%0b busy=%0b want 1/0", miner_reset, busy); end
    vectors++; if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_async_io got rdy=%0b vld=%0b data=%h want 1/0/00", rx_ready, tx_valid, tx_data); end
    vectors++; if (midstate !== 256'd0 || nonce_max !== 32'd0) begin miscompares++; $display("FAIL rst_async_regs got=%h/%h want=0", midstate, nonce_max); end
    @(posedge hash_clk); #1;
    reset_n = 1'b1;
    @(posedge hash_clk); #1;
    send_packet(MS, WD, 32'h00000042, 32'h00000042, 8'h00);
    wait_run(ok);
    repeat (3) begin @(posedge hash_clk); #1; end
    golden_nonce = 32'hCAFEF00D; new_golden_nonce = 1'b1;
    @(posedge hash_clk); #1;
    new_golden_nonce = 1'b0;
    collect_frame(0, f, u, r, t);
    vectors++; if (f !== 40'h01_CAFEF00D || t !== 0 || ok !== 1) begin miscompares++; $display("FAIL rst_next_job got=%h tmo=%0d run=%0d want=01cafef00d", f, t, ok); end
  endtask

`ifdef MINER_JOB_CHECKSUM_EN
  task automatic test_checksum_nak();
    logic [39:0] f; int u, r, t, runs, n;
    send_packet(MS, WD, 32'h00000010, 32'h00000020, 8'h5A);
    runs = 0; n = 0;
    while (!tx_valid && n < 100) begin
      @(posedge hash_clk); #1; n++;
      if (miner_reset !== 1'b1) runs++;
    end
    vectors++; if (runs !== 0) begin miscompares++; $display("FAIL nak_miner_released got=%0d want=0", runs); end
    collect_frame(0, f, u, r, t);
    vectors++; if (f !== 40'h03_00000000 || t !== 0) begin miscompares++; $display("FAIL nak_frame got=%h tmo=%0d want=0300000000", f, t); end
  endtask
`endif

  initial begin
    rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    golden_nonce = 32'h0; new_golden_nonce = 1'b0;
    test_reset();
    test_found();
    test_exhausted();
    test_inverted_range();
    test_back_pressure();
    test_reset_mid_run();
`ifdef MINER_JOB_CHECKSUM_EN
    test_checksum_nak();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
